// File: rtl/cluster_pwr_seq_pkg.sv
// Shared state encoding and default timing for the cluster power sequencer.
// Default build has no drain timeout; see CLUSTER_PWR_SEQ_TIMEOUT_EN.
package cluster_pwr_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_PWR_ON   = 3'd1,
    ST_CLK_ON   = 3'd2,
    ST_RST_REL  = 3'd3,
    ST_RUN      = 3'd4,
    ST_DRAIN    = 3'd5,
    ST_ISO      = 3'd6,
    ST_OFF_WAIT = 3'd7
  } state_e;

  localparam int unsigned PWR_SETTLE_DEF  = 16;
  localparam int unsigned CLK_SETTLE_DEF  = 8;
  localparam int unsigned RST_HOLD_DEF    = 4;
  localparam int unsigned IDLE_DEF        = 8;
  localparam int unsigned OFF_SETTLE_DEF  = 16;
  localparam int unsigned DRAIN_TMO_DEF   = 1024;

  function automatic int unsigned max2(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // counter reload value for an N-cycle spacing; 0 behaves like 1
  function automatic int unsigned span(int unsigned n);
    return (n == 0) ? 0 : n - 1;
  endfunction

endpackage

// File: rtl/cluster_pwr_seq_cnt.sv
// Loadable down-counter with zero flag, shared by all settle delays.
// Holds at zero until reloaded.
module cluster_pwr_seq_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cluster_pwr_seq.sv
// Cluster power-up/boot/power-down sequencer in the SoC domain.
// Define CLUSTER_PWR_SEQ_TIMEOUT_EN to bound the drain wait.
module cluster_pwr_seq
  import cluster_pwr_seq_pkg::*;
#(
  parameter int unsigned PWR_SETTLE_CYC    = PWR_SETTLE_DEF,
  parameter int unsigned CLK_SETTLE_CYC    = CLK_SETTLE_DEF,
  parameter int unsigned RST_HOLD_CYC      = RST_HOLD_DEF,
  parameter int unsigned IDLE_CYC          = IDLE_DEF,
  parameter int unsigned OFF_SETTLE_CYC    = OFF_SETTLE_DEF,
  parameter int unsigned DRAIN_TIMEOUT_CYC = DRAIN_TMO_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        test_mode_i,
  input  logic        cmd_valid_i,
  input  logic        cmd_up_i,
  input  logic [63:0] cmd_boot_addr_i,
  output logic        cmd_ready_o,
  output logic        cmd_err_o,
  output logic        done_o,
  output logic [2:0]  state_o,
  input  logic        cluster_busy_i,
  output logic        cluster_pow_o,
  output logic        cluster_byp_o,
  output logic        cluster_clk_en_o,
  output logic        cluster_rstn_o,
  output logic        cluster_fetch_enable_o,
  output logic [63:0] cluster_boot_addr_o,
  output logic        cluster_test_en_o,
  output logic        timeout_o
);

  localparam int unsigned MAXP = max2(
    max2(max2(PWR_SETTLE_CYC, CLK_SETTLE_CYC),
         max2(RST_HOLD_CYC, IDLE_CYC)),
    max2(OFF_SETTLE_CYC, DRAIN_TIMEOUT_CYC));
  localparam int unsigned CW = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] PWR_L  = CW'(span(PWR_SETTLE_CYC));
  localparam logic [CW-1:0] CLK_L  = CW'(span(CLK_SETTLE_CYC));
  localparam logic [CW-1:0] RST_L  = CW'(span(RST_HOLD_CYC));
  localparam logic [CW-1:0] IDLE_L = CW'(span(IDLE_CYC));
  localparam logic [CW-1:0] OFF_L  = CW'(span(OFF_SETTLE_CYC));

  state_e        state_q, state_d;
  logic [63:0]   boot_q, boot_d;
  logic [CW-1:0] idle_q, idle_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          pow_q, pow_d;
  logic          clk_en_q, clk_en_d;
  logic          rstn_q, rstn_d;
  logic          fetch_q, fetch_d;
  logic          test_en_q;

  logic          accept;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_zero;
  logic          tmo_hit;

  assign cmd_ready_o = (state_q == ST_OFF) || (state_q == ST_RUN);
  assign accept      = cmd_valid_i && cmd_ready_o;

  cluster_pwr_seq_cnt #(
    .W (CW)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (cnt_load),
    .val_i  (cnt_val),
    .zero_o (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    boot_d   = boot_q;
    idle_d   = '0;
    err_d    = 1'b0;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    unique case (state_q)
      ST_OFF: begin
        if (accept && cmd_up_i) begin
          boot_d   = cmd_boot_addr_i;
          state_d  = ST_PWR_ON;
          cnt_load = 1'b1;
          cnt_val  = PWR_L;
        end else if (accept) begin
          err_d = 1'b1;
        end
      end
      ST_PWR_ON: begin
        if (cnt_zero) begin
          state_d  = ST_CLK_ON;
          cnt_load = 1'b1;
          cnt_val  = CLK_L;
        end
      end
      ST_CLK_ON: begin
        if (cnt_zero) begin
          state_d  = ST_RST_REL;
          cnt_load = 1'b1;
          cnt_val  = RST_L;
        end
      end
      ST_RST_REL: begin
        if (cnt_zero) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (accept && !cmd_up_i) begin
          state_d = ST_DRAIN;
        end else if (accept) begin
          err_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        idle_d = cluster_busy_i ? '0 : idle_q + CW'(1);
        if ((!cluster_busy_i && idle_q == IDLE_L) || tmo_hit) begin
          state_d = ST_ISO;
        end
      end
      ST_ISO: begin
        state_d  = ST_OFF_WAIT;
        cnt_load = 1'b1;
        cnt_val  = OFF_L;
      end
      ST_OFF_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_OFF;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  // cluster controls follow the state being entered, so they change on the same edge
  always_comb begin
    pow_d    = (state_d != ST_OFF) && (state_d != ST_OFF_WAIT);
    clk_en_d = (state_d inside {ST_CLK_ON, ST_RST_REL, ST_RUN, ST_DRAIN})
               || test_mode_i;
    rstn_d   = state_d inside {ST_RST_REL, ST_RUN, ST_DRAIN};
    fetch_d  = (state_d == ST_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_OFF;
      boot_q    <= '0;
      idle_q    <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      pow_q     <= 1'b0;
      clk_en_q  <= 1'b0;
      rstn_q    <= 1'b0;
      fetch_q   <= 1'b0;
      test_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      boot_q    <= boot_d;
      idle_q    <= idle_d;
      err_q     <= err_d;
      done_q    <= done_d;
      pow_q     <= pow_d;
      clk_en_q  <= clk_en_d;
      rstn_q    <= rstn_d;
      fetch_q   <= fetch_d;
      test_en_q <= test_mode_i;
    end
  end

`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_L = CW'(span(DRAIN_TIMEOUT_CYC));

  logic [CW-1:0] drain_q, drain_d;
  logic          timeout_q, timeout_d;
  logic          up_acc;

  assign up_acc = accept && cmd_up_i && (state_q == ST_OFF);

  always_comb begin
    drain_d   = (state_q == ST_DRAIN) ? drain_q + CW'(1) : '0;
    tmo_hit   = (state_q == ST_DRAIN) && (drain_q == TMO_L);
    timeout_d = timeout_q;
    if (tmo_hit) begin
      timeout_d = 1'b1;
    end else if (up_acc) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drain_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      drain_q   <= drain_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign cmd_err_o              = err_q;
  assign done_o                 = done_q;
  assign state_o                = state_q;
  assign cluster_pow_o          = pow_q;
  assign cluster_byp_o          = 1'b0;
  assign cluster_clk_en_o       = clk_en_q;
  assign cluster_rstn_o         = rstn_q;
  assign cluster_fetch_enable_o = fetch_q;
  assign cluster_boot_addr_o    = boot_q;
  assign cluster_test_en_o      = test_en_q;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// Randomized bench for cluster_pwr_seq against a timeline reference model.
// Honors CLUSTER_PWR_SEQ_TIMEOUT_EN when the design is built with it.
module tb_cluster_pwr_seq;

  localparam int P  = 16;
  localparam int C  = 8;
  localparam int R  = 4;
  localparam int I  = 8;
  localparam int O  = 16;
  localparam int TO = 1024;
  localparam logic [12:0] RST_VEC = 13'h020;

  localparam int M_OFF   = 0;
  localparam int M_BOOT  = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;
  localparam int M_SHUT  = 4;

  logic        clk = 1'b0;
  logic        rst, tm, v, up, busy;
  logic [63:0] addr;
  logic        cmd_ready, cmd_err, done, pow, byp, clk_en, rstn, fetch, test_en, tmo;
  logic [2:0]  state;
  logic [63:0] boot;
  logic [12:0] dv;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          ph = M_OFF;
  int          ev = 0;
  int          low_run = 0;
  logic [63:0] m_boot = '0;
  logic        m_done = 1'b0;
  logic        m_err  = 1'b0;
  logic        m_tmo  = 1'b0;
  logic        m_tm   = 1'b0;

  always #5 clk = ~clk;

  cluster_pwr_seq dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .test_mode_i            (tm),
    .cmd_valid_i            (v),
    .cmd_up_i               (up),
    .cmd_boot_addr_i        (addr),
    .cmd_ready_o            (cmd_ready),
    .cmd_err_o              (cmd_err),
    .done_o                 (done),
    .state_o                (state),
    .cluster_busy_i         (busy),
    .cluster_pow_o          (pow),
    .cluster_byp_o          (byp),
    .cluster_clk_en_o       (clk_en),
    .cluster_rstn_o         (rstn),
    .cluster_fetch_enable_o (fetch),
    .cluster_boot_addr_o    (boot),
    .cluster_test_en_o      (test_en),
    .timeout_o              (tmo)
  );

  assign dv = {pow, byp, clk_en, rstn, fetch, done, cmd_err,
               cmd_ready, tmo, test_en, state};

  // expected outputs from the phase and the time elapsed since it began
  function automatic logic [12:0] expv();
    int k;
    logic pw, ck, rn, fe;
    logic [2:0] st;
    k = cyc - ev;
    pw = 1'b0; ck = 1'b0; rn = 1'b0; fe = 1'b0; st = 3'd0;
    case (ph)
      M_BOOT: begin
        pw = 1'b1;
        ck = (k >= P);
        rn = (k >= P + C);
        st = (k < P) ? 3'd1 : ((k < P + C) ? 3'd2 : 3'd3);
      end
      M_RUN:   begin pw = 1'b1; ck = 1'b1; rn = 1'b1; fe = 1'b1; st = 3'd4; end
      M_DRAIN: begin pw = 1'b1; ck = 1'b1; rn = 1'b1; st = 3'd5; end
      M_SHUT:  begin pw = (k < 1); st = (k < 1) ? 3'd6 : 3'd7; end
      default: ;
    endcase
    return {pw, 1'b0, ck | m_tm, rn, fe, m_done, m_err,
            (ph == M_OFF || ph == M_RUN), m_tmo, m_tm, st};
  endfunction

  task automatic clk_step();
    logic s_rst, s_v, s_up, s_busy, s_tm, acc, to;
    logic [63:0] s_addr;
    int n;
    s_rst = rst; s_v = v; s_up = up; s_busy = busy; s_tm = tm; s_addr = addr;
    @(posedge clk);
    cyc++;
    n = cyc;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (s_rst) begin
      ph = M_OFF; ev = n; m_boot = '0; m_tmo = 1'b0; m_tm = 1'b0;
    end else begin
      m_tm = s_tm;
      acc = s_v && (ph == M_OFF || ph == M_RUN);
      case (ph)
        M_OFF: if (acc) begin
          if (s_up) begin
            ph = M_BOOT; ev = n; m_boot = s_addr; m_tmo = 1'b0;
          end else m_err = 1'b1;
        end
        M_BOOT: if (n - ev == P + C + R) begin
          ph = M_RUN; ev = n; m_done = 1'b1;
        end
        M_RUN: if (acc) begin
          if (!s_up) begin
            ph = M_DRAIN; ev = n; low_run = 0;
          end else m_err = 1'b1;
        end
        M_DRAIN: begin
          low_run = s_busy ? 0 : low_run + 1;
          to = 1'b0;
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
          to = (n - ev == TO);
`endif
          if (to) m_tmo = 1'b1;
          if (low_run == I || to) begin
            ph = M_SHUT; ev = n;
          end
        end
        M_SHUT: if (n - ev == 1 + O) begin
          ph = M_OFF; ev = n; m_done = 1'b1;
        end
        default: ph = M_OFF;
      endcase
    end
    #1;
  endtask

  task automatic go_up();
    v = 1'b1; up = 1'b1; addr = {$urandom, $urandom};
    clk_step();
    v = 1'b0;
    repeat (30) clk_step();
  endtask

  task automatic go_down();
    v = 1'b1; up = 1'b0; busy = 1'b0;
    clk_step();
    v = 1'b0;
    repeat (30) clk_step();
  endtask

  task automatic test_reset();
    rst = 1'b1; v = 1'b0; up = 1'b0; addr = '0; busy = 1'b0; tm = 1'b0;
    clk_step();
    clk_step();
    total++;
    if (dv !== RST_VEC) begin
      bad++; $display("FAIL reset_vec got=%h exp=%h", dv, RST_VEC);
    end
    total++;
    if (boot !== 64'h0) begin
      bad++; $display("FAIL reset_boot got=%h exp=0", boot);
    end
    rst = 1'b0;
    clk_step();
    total++;
    if (dv !== expv()) begin
      bad++; $display("FAIL reset_idle got=%h exp=%h", dv, expv());
    end
  endtask

  task automatic test_boot();
    int t, pr, cr, rr, fr, dn;
    pr = -1; cr = -1; rr = -1; fr = -1; dn = -1;
    addr = 64'h1C008080; up = 1'b1; v = 1'b1; t = cyc;
    clk_step();
    v = 1'b0; addr = {$urandom, $urandom}; up = 1'($urandom_range(1));
    for (int i = 0; i < 34; i++) begin
      total++;
      if (dv !== expv() || boot !== m_boot) begin
        bad++;
        $display("FAIL boot_seq cyc=%0d got=%h/%h exp=%h/%h", cyc, dv, boot, expv(), m_boot);
      end
      if (i == 0) begin
        total++;
        if (boot !== 64'h1C008080) begin
          bad++; $display("FAIL boot_addr got=%h exp=1c008080", boot);
        end
      end
      if (pr < 0 && pow) pr = cyc;
      if (cr < 0 && clk_en) cr = cyc;
      if (rr < 0 && rstn) rr = cyc;
      if (fr < 0 && fetch) fr = cyc;
      if (dn < 0 && done) dn = cyc;
      clk_step();
    end
    total++;
    if (pr - t != 1)  begin bad++; $display("FAIL pow_rise got=%0d exp=1", pr - t); end
    total++;
    if (cr - t != 17) begin bad++; $display("FAIL clk_rise got=%0d exp=17", cr - t); end
    total++;
    if (rr - t != 25) begin bad++; $display("FAIL rstn_rise got=%0d exp=25", rr - t); end
    total++;
    if (fr - t != 29) begin bad++; $display("FAIL fetch_rise got=%0d exp=29", fr - t); end
    total++;
    if (dn - t != 29) begin bad++; $display("FAIL boot_done got=%0d exp=29", dn - t); end
  endtask

  task automatic test_drain();
    int t, b, rf, cf, pf, dn;
    rf = -1; cf = -1; pf = -1; dn = -1;
    v = 1'b1; up = 1'b0; busy = 1'b1; t = cyc;
    clk_step();
    v = 1'b0;
    total++;
    if (fetch !== 1'b0 || state !== 3'd5) begin
      bad++; $display("FAIL drain_entry cyc=%0d got=%b/%0d exp=0/5", cyc - t, fetch, state);
    end
    for (int i = 0; i < 19; i++) begin
      total++;
      if (dv !== expv()) begin
        bad++; $display("FAIL drain_busy cyc=%0d got=%h exp=%h", cyc, dv, expv());
      end
      clk_step();
    end
    busy = 1'b0; b = cyc;
    for (int i = 0; i < 40; i++) begin
      total++;
      if (dv !== expv()) begin
        bad++; $display("FAIL drain_seq cyc=%0d got=%h exp=%h", cyc, dv, expv());
      end
      if (rf < 0 && !rstn) rf = cyc;
      if (cf < 0 && !clk_en) cf = cyc;
      if (pf < 0 && !pow) pf = cyc;
      if (dn < 0 && done) dn = cyc;
      clk_step();
    end
    total++;
    if (rf - b != 8 || cf != rf) begin
      bad++; $display("FAIL iso_time got=%0d/%0d exp=8/8", rf - b, cf - b);
    end
    total++;
    if (pf - rf != 1)  begin bad++; $display("FAIL pow_fall got=%0d exp=1", pf - rf); end
    total++;
    if (dn - pf != 16) begin bad++; $display("FAIL off_done got=%0d exp=16", dn - pf); end
    total++;
    if (state !== 3'd0) begin bad++; $display("FAIL off_state got=%0d exp=0", state); end
  endtask

  task automatic test_busy_toggle();
    int d, iso;
    iso = -1;
    go_up();
    v = 1'b1; up = 1'b0; busy = 1'b0;
    clk_step();
    v = 1'b0; d = cyc;
    for (int j = 0; j < 40; j++) begin
      busy = (j == 7);
      total++;
      if (dv !== expv()) begin
        bad++; $display("FAIL toggle_seq cyc=%0d got=%h exp=%h", cyc, dv, expv());
      end
      if (iso < 0 && state == 3'd6) iso = cyc;
      clk_step();
    end
    total++;
    if (iso - d != 16) begin
      bad++; $display("FAIL toggle_iso got=%0d exp=16", iso - d);
    end
  endtask

  task automatic test_illegal();
    logic [63:0] a;
    v = 1'b1; up = 1'b0;
    clk_step();
    v = 1'b0;
    total++;
    if (cmd_err !== 1'b1 || state !== 3'd0) begin
      bad++; $display("FAIL down_in_off got=%b/%0d exp=1/0", cmd_err, state);
    end
    clk_step();
    total++;
    if (cmd_err !== 1'b0) begin bad++; $display("FAIL err_pulse got=%b exp=0", cmd_err); end
    go_up();
    a = m_boot;
    v = 1'b1; up = 1'b1; addr = ~a;
    clk_step();
    v = 1'b0;
    total++;
    if (cmd_err !== 1'b1 || boot !== a || state !== 3'd4) begin
      bad++; $display("FAIL up_in_run got=%b/%h/%0d exp=1/%h/4", cmd_err, boot, state, a);
    end
    go_down();
  endtask

  task automatic test_blocked();
    logic [63:0] a;
    a = {$urandom, $urandom};
    v = 1'b1; up = 1'b1; addr = a;
    clk_step();
    for (int i = 0; i < 6; i++) begin
      up = 1'($urandom_range(1)); addr = {$urandom, $urandom};
      total++;
      if (cmd_ready !== 1'b0 || cmd_err !== 1'b0 || state !== 3'd1 || boot !== a) begin
        bad++;
        $display("FAIL blocked got=%b/%b/%0d/%h exp=0/0/1/%h", cmd_ready, cmd_err, state, boot, a);
      end
      clk_step();
    end
    v = 1'b0;
    repeat (30) clk_step();
    go_down();
  endtask

  task automatic test_reset_mid();
    v = 1'b1; up = 1'b1; addr = {$urandom, $urandom};
    clk_step();
    v = 1'b0;
    repeat (19) clk_step();
    total++;
    if (state !== 3'd2) begin bad++; $display("FAIL mid_clk_on got=%0d exp=2", state); end
    rst = 1'b1;
    clk_step();
    total++;
    if (dv !== RST_VEC || boot !== 64'h0) begin
      bad++; $display("FAIL mid_reset got=%h/%h exp=%h/0", dv, boot, RST_VEC);
    end
    rst = 1'b0;
    clk_step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      v    = ($urandom_range(7) == 0);
      up   = 1'($urandom_range(1));
      addr = {$urandom, $urandom};
      busy = ($urandom_range(3) == 0);
      tm   = ($urandom_range(15) == 0);
      rst  = ($urandom_range(399) == 0);
      clk_step();
      total++;
      if (dv !== expv() || boot !== m_boot) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h/%h exp=%h/%h", cyc, dv, boot, expv(), m_boot);
      end
    end
    rst = 1'b0; tm = 1'b0; v = 1'b0; busy = 1'b0;
    repeat (2) clk_step();
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    clk_step();
  endtask

`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int e, iso, tf;
    iso = -1; tf = -1;
    go_up();
    v = 1'b1; up = 1'b0; busy = 1'b1;
    clk_step();
    v = 1'b0; e = cyc;
    for (int i = 0; i < 1045; i++) begin
      total++;
      if (dv !== expv()) begin
        bad++; $display("FAIL tmo_seq cyc=%0d got=%h exp=%h", cyc, dv, expv());
      end
      if (iso < 0 && state == 3'd6) iso = cyc;
      if (tf < 0 && tmo) tf = cyc;
      clk_step();
    end
    total++;
    if (iso - e != TO || tf != iso) begin
      bad++; $display("FAIL tmo_iso got=%0d/%0d exp=%0d", iso - e, tf - e, TO);
    end
    total++;
    if (tmo !== 1'b1 || state !== 3'd0) begin
      bad++; $display("FAIL tmo_sticky got=%b/%0d exp=1/0", tmo, state);
    end
    v = 1'b1; up = 1'b1; busy = 1'b0;
    clk_step();
    v = 1'b0;
    total++;
    if (tmo !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b exp=0", tmo); end
    repeat (30) clk_step();
    go_down();
  endtask
`endif

  initial begin
    test_reset();
    test_boot();
    test_drain();
    test_busy_toggle();
    test_illegal();
    test_blocked();
    test_reset_mid();
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
